// File: rtl/i2c_slave_if.sv
// i2c_slave_if: I2C pin pair plus FIFO/status handshake of the responder.
// sda is open-drain: sda_oe_o=1 pulls the line low, sda_i is the resolved line level.
interface i2c_slave_if;
    logic         scl_i;
    logic         sda_i;
    logic         sda_oe_o;
    logic [127:0] slv_tfifo_i;
    logic [127:0] slv_rfifo_o;
    logic [7:0]   slv_status_o;
    logic         slv_done_o;
    modport slave (
        input  scl_i, sda_i, slv_tfifo_i,
        output sda_oe_o, slv_rfifo_o, slv_status_o, slv_done_o
    );
    modport master (
        output scl_i, sda_i, slv_tfifo_i,
        input  sda_oe_o, slv_rfifo_o, slv_status_o, slv_done_o
    );
endinterface

// File: rtl/i2c_slave.sv
// i2c_slave: oversampled I2C responder with a 16-byte write buffer and 16-byte read payload.
module i2c_slave #(
    parameter logic [6:0] SLV_ADDR = 7'h5A
) (
    input logic clk,
    input logic rst,
    i2c_slave_if.slave bus
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ADDR      = 3'd1;
    localparam logic [2:0] ADDR_ACK  = 3'd2;
    localparam logic [2:0] WDATA     = 3'd3;
    localparam logic [2:0] WACK      = 3'd4;
    localparam logic [2:0] RDATA     = 3'd5;
    localparam logic [2:0] RACK      = 3'd6;
    localparam logic [2:0] WAIT_STOP = 3'd7;

    logic [1:0]   scl_sync_q, sda_sync_q;
    logic         scl_p_q, sda_p_q;
    logic [2:0]   state_q, state_d;
    logic [3:0]   bit_q, bit_d;
    logic [7:0]   sr_q, sr_d, tx_q, tx_d;
    logic [4:0]   byte_cnt_q, byte_cnt_d;
    logic         is_rd_q, is_rd_d, ovf_q, ovf_d, matched_q, matched_d;
    logic         sda_oe_q, sda_oe_d, done_q, done_d;
    logic [127:0] rfifo_q, rfifo_d;

    logic       scl_s, sda_s, scl_rise, scl_fall, start, stop;
    logic [7:0] sr_in, rd_byte;
    logic [6:0] k_sh;

    assign scl_s    = scl_sync_q[1];
    assign sda_s    = sda_sync_q[1];
    assign scl_rise = scl_s & ~scl_p_q;
    assign scl_fall = ~scl_s & scl_p_q;
    assign start    = scl_s & sda_p_q & ~sda_s;
    assign stop     = scl_s & ~sda_p_q & sda_s;
    assign sr_in    = {sr_q[6:0], sda_s};
    assign k_sh     = {byte_cnt_q[3:0], 3'b000};
    assign rd_byte  = bus.slv_tfifo_i[7'd127 - k_sh -: 8];

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        sr_d       = sr_q;
        tx_d       = tx_q;
        byte_cnt_d = byte_cnt_q;
        is_rd_d    = is_rd_q;
        ovf_d      = ovf_q;
        matched_d  = matched_q;
        sda_oe_d   = sda_oe_q;
        done_d     = 1'b0;
        rfifo_d    = rfifo_q;
        if (start) begin
            state_d    = ADDR;
            bit_d      = 4'd0;
            byte_cnt_d = 5'd0;
            ovf_d      = 1'b0;
            sda_oe_d   = 1'b0;
            matched_d  = 1'b0;
        end else if (stop) begin
            state_d   = IDLE;
            sda_oe_d  = 1'b0;
            done_d    = matched_q;
            matched_d = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        sr_d  = sr_in;
                        bit_d = bit_q + 4'd1;
                    end else if (scl_fall && bit_q == 4'd8) begin
                        bit_d = 4'd0;
                        if (sr_q[7:1] == SLV_ADDR) begin
                            state_d   = ADDR_ACK;
                            sda_oe_d  = 1'b1;
                            is_rd_d   = sr_q[0];
                            matched_d = 1'b1;
                            rfifo_d   = sr_q[0] ? rfifo_q : '0;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                // A read byte is loaded on the falling edge that ends the preceding ACK slot
                ADDR_ACK, RACK: begin
                    if (state_q == RACK && scl_rise && sda_s) begin
                        state_d = WAIT_STOP;
                    end else if (scl_fall && (state_q == RACK || is_rd_q)) begin
                        state_d  = RDATA;
                        sda_oe_d = ~rd_byte[7];
                        tx_d     = {rd_byte[6:0], 1'b0};
                        bit_d    = 4'd1;
                    end else if (scl_fall) begin
                        state_d  = WDATA;
                        sda_oe_d = 1'b0;
                        bit_d    = 4'd0;
                    end
                end
                WDATA: begin
                    if (scl_rise) begin
                        sr_d  = sr_in;
                        bit_d = bit_q + 4'd1;
                        if (bit_q == 4'd7 && byte_cnt_q[4]) begin
                            ovf_d = 1'b1;
                        end else if (bit_q == 4'd7) begin
                            rfifo_d[7'd127 - k_sh -: 8] = sr_in;
                            byte_cnt_d = byte_cnt_q + 5'd1;
                        end
                    end else if (scl_fall && bit_q == 4'd8) begin
                        bit_d    = 4'd0;
                        state_d  = ovf_q ? WAIT_STOP : WACK;
                        sda_oe_d = ~ovf_q;
                    end
                end
                WACK: begin
                    if (scl_fall) begin
                        state_d  = WDATA;
                        sda_oe_d = 1'b0;
                    end
                end
                RDATA: begin
                    if (scl_fall && bit_q == 4'd8) begin
                        state_d    = RACK;
                        sda_oe_d   = 1'b0;
                        bit_d      = 4'd0;
                        byte_cnt_d = byte_cnt_q[4] ? byte_cnt_q : byte_cnt_q + 5'd1;
                    end else if (scl_fall) begin
                        sda_oe_d = ~tx_q[7];
                        tx_d     = {tx_q[6:0], 1'b0};
                        bit_d    = bit_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_p_q    <= 1'b1;
            sda_p_q    <= 1'b1;
            state_q    <= IDLE;
            bit_q      <= 4'd0;
            sr_q       <= 8'd0;
            tx_q       <= 8'd0;
            byte_cnt_q <= 5'd0;
            is_rd_q    <= 1'b0;
            ovf_q      <= 1'b0;
            matched_q  <= 1'b0;
            sda_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            rfifo_q    <= '0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], bus.scl_i};
            sda_sync_q <= {sda_sync_q[0], bus.sda_i};
            scl_p_q    <= scl_s;
            sda_p_q    <= sda_s;
            state_q    <= state_d;
            bit_q      <= bit_d;
            sr_q       <= sr_d;
            tx_q       <= tx_d;
            byte_cnt_q <= byte_cnt_d;
            is_rd_q    <= is_rd_d;
            ovf_q      <= ovf_d;
            matched_q  <= matched_d;
            sda_oe_q   <= sda_oe_d;
            done_q     <= done_d;
            rfifo_q    <= rfifo_d;
        end
    end

    assign bus.sda_oe_o     = sda_oe_q;
    assign bus.slv_rfifo_o  = rfifo_q;
    assign bus.slv_status_o = {state_q != IDLE, is_rd_q, ovf_q, byte_cnt_q};
    assign bus.slv_done_o   = done_q;
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master driving i2c_slave, checked against a byte-level model.
module tb_i2c_slave;
    localparam int Q = 4;
    logic clk = 1'b0, rst = 1'b1, scl = 1'b1, m_sda = 1'b1;
    logic [127:0] tfifo = '0;
    logic [127:0] exp_rf = '0;
    int errors = 0, checks = 0, done_cnt = 0, low_cnt = 0;

    i2c_slave_if bus ();
    assign bus.scl_i       = scl;
    assign bus.sda_i       = m_sda & ~bus.sda_oe_o;
    assign bus.slv_tfifo_i = tfifo;

    i2c_slave #(.SLV_ADDR(7'h5A)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.slv_done_o) done_cnt++;
        if (bus.sda_oe_o) low_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_x(input logic b, output logic s);
        wq(Q); m_sda = b;
        wq(Q); scl = 1'b1;
        wq(Q); s = bus.sda_i;
        wq(Q); scl = 1'b0;
    endtask

    task automatic start_c;
        if (!scl) begin
            wq(Q); m_sda = 1'b1;
            wq(Q); scl = 1'b1;
        end
        wq(2 * Q); m_sda = 1'b0;
        wq(2 * Q); scl = 1'b0;
    endtask

    task automatic stop_c;
        wq(Q); m_sda = 1'b0;
        wq(Q); scl = 1'b1;
        wq(2 * Q); m_sda = 1'b1;
        wq(4 * Q);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_x(b[i], s);
        bit_x(1'b1, s);
        ack = ~s;
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, s);
            d[i] = s;
        end
        bit_x(~mack, s);
    endtask

    task automatic do_write(input string tag, input logic [7:0] data[$]);
        logic ack;
        int d0;
        int n;
        d0 = done_cnt;
        n = data.size();
        exp_rf = '0;
        start_c;
        wr_byte({7'h5A, 1'b0}, ack);
        check({tag, " addr_ack"}, 128'(ack), 128'(1));
        foreach (data[i]) begin
            wr_byte(data[i], ack);
            check($sformatf("%s ack%0d", tag, i), 128'(ack), 128'(i < 16));
            if (i < 16) exp_rf[127 - 8 * i -: 8] = data[i];
        end
        stop_c;
        check({tag, " rfifo"}, bus.slv_rfifo_o, exp_rf);
        check({tag, " status"}, 128'(bus.slv_status_o),
              128'({1'b0, 1'b0, n > 16, 5'(n > 16 ? 16 : n)}));
        check({tag, " done"}, 128'(done_cnt - d0), 128'(1));
    endtask

    task automatic do_read(input string tag, input int n);
        logic ack;
        logic [7:0] d;
        int d0;
        int k;
        d0 = done_cnt;
        start_c;
        wr_byte({7'h5A, 1'b1}, ack);
        check({tag, " addr_ack"}, 128'(ack), 128'(1));
        for (int i = 0; i < n; i++) begin
            rd_byte(i != n - 1, d);
            k = i < 16 ? i : 0;
            check($sformatf("%s byte%0d", tag, i), 128'(d), 128'(tfifo[127 - 8 * k -: 8]));
        end
        stop_c;
        check({tag, " status"}, 128'(bus.slv_status_o),
              128'({1'b0, 1'b1, 1'b0, 5'(n > 16 ? 16 : n)}));
        check({tag, " rfifo_kept"}, bus.slv_rfifo_o, exp_rf);
        check({tag, " done"}, 128'(done_cnt - d0), 128'(1));
    endtask

    initial begin
        logic [7:0] q[$];
        logic ack, s;
        logic [7:0] d;
        int d0, l0;
        wq(4);
        check("rst status", 128'(bus.slv_status_o), 128'(0));
        check("rst rfifo", bus.slv_rfifo_o, 128'(0));
        check("rst sda_oe", 128'(bus.sda_oe_o), 128'(0));
        check("rst done", 128'(bus.slv_done_o), 128'(0));
        rst = 1'b0;
        wq(4);

        q = {8'h12, 8'h34};
        do_write("wr2", q);
        check("wr2 top16", 128'(bus.slv_rfifo_o[127:112]), 128'(16'h1234));

        tfifo = {16'hA55A, 32'($urandom), 32'($urandom), 32'($urandom), 16'($urandom)};
        do_read("rd2", 2);

        d0 = done_cnt;
        l0 = low_cnt;
        start_c;
        wr_byte(8'h20, ack);
        check("miss ack", 128'(ack), 128'(0));
        wr_byte(8'($urandom), ack);
        stop_c;
        check("miss sda_low", 128'(low_cnt - l0), 128'(0));
        check("miss done", 128'(done_cnt - d0), 128'(0));
        check("miss rfifo", bus.slv_rfifo_o, exp_rf);

        q = {};
        for (int i = 0; i < 17; i++) q.push_back(8'($urandom));
        do_write("ovf", q);

        for (int r = 0; r < 3; r++) begin
            q = {};
            for (int i = 0; i < int'($urandom_range(1, 16)); i++) q.push_back(8'($urandom));
            do_write($sformatf("rwr%0d", r), q);
        end

        tfifo = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
        do_read("rd5", 5);

        d0 = done_cnt;
        start_c;
        wr_byte(8'hB4, ack);
        check("sr waddr_ack", 128'(ack), 128'(1));
        wr_byte(8'h77, ack);
        check("sr wdata_ack", 128'(ack), 128'(1));
        start_c;
        wr_byte(8'hB5, ack);
        check("sr raddr_ack", 128'(ack), 128'(1));
        rd_byte(1'b0, d);
        check("sr rdata", 128'(d), 128'(tfifo[127:120]));
        stop_c;
        exp_rf = {8'h77, 120'd0};
        check("sr rfifo", bus.slv_rfifo_o, exp_rf);
        check("sr status", 128'(bus.slv_status_o), 128'({1'b0, 1'b1, 1'b0, 5'd1}));
        check("sr done", 128'(done_cnt - d0), 128'(1));

        tfifo = {8'h00, 120'(tfifo)};
        start_c;
        wr_byte(8'hB5, ack);
        check("rrst addr_ack", 128'(ack), 128'(1));
        for (int i = 0; i < 3; i++) bit_x(1'b1, s);
        wq(Q); wq(Q); scl = 1'b1; wq(Q);
        check("rrst driving", 128'(bus.sda_oe_o), 128'(1));
        rst = 1'b1;
        wq(1);
        check("rrst sda_oe", 128'(bus.sda_oe_o), 128'(0));
        check("rrst status", 128'(bus.slv_status_o), 128'(0));
        check("rrst rfifo", bus.slv_rfifo_o, 128'(0));
        check("rrst done", 128'(bus.slv_done_o), 128'(0));
        wq(4);
        rst = 1'b0;
        wq(8);
        exp_rf = '0;
        q = {8'($urandom), 8'($urandom), 8'($urandom)};
        do_write("post_rst", q);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
